mem_port_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch stage and the data-memory stage of the 5-stage core. Each requester holds a level request until it receives a one-cycle acknowledge. The arbiter sequences every access through issue, latency-wait and response phases, and returns the read data registered. It drives per-requester stall outputs that feed the pipeline stall/bubble controller.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_port_arbiter_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Optional round-robin arbitration is enabled by defining MEM_PORT_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IF = 1'b0;
    localparam req_id_t REQ_D  = 1'b1;

    localparam logic [1:0] WL_BYTE = 2'd0;
    localparam logic [1:0] WL_HALF = 2'd1;
    localparam logic [1:0] WL_WORD = 2'd2;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    // Out-of-range latencies are pulled to the nearest legal value so the counter never wraps.
    function automatic int lat_clamp(input int lat);
        if (lat < MEM_LAT_MIN) begin
            return MEM_LAT_MIN;
        end else if (lat > MEM_LAT_MAX) begin
            return MEM_LAT_MAX;
        end else begin
            return lat;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Round-robin tie-break is compiled only when MEM_PORT_ARB_RR_EN is defined.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    if_req_i,
    input  logic    d_req_i,
`ifdef MEM_PORT_ARB_RR_EN
    input  req_id_t last_gnt_i,
`endif
    output logic    gnt_valid_o,
    output req_id_t gnt_id_o
);

    // Select the winner; data holds the older instruction so it wins ties by default.
    always_comb begin
        gnt_valid_o = if_req_i | d_req_i;
        gnt_id_o    = REQ_D;
        if (if_req_i && d_req_i) begin
`ifdef MEM_PORT_ARB_RR_EN
            gnt_id_o = (last_gnt_i == REQ_D) ? REQ_IF : REQ_D;
`else
            gnt_id_o = REQ_D;
`endif
        end else if (if_req_i) begin
            gnt_id_o = REQ_IF;
        end else begin
            gnt_id_o = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences fetch and data accesses onto one single-port memory (IDLE/ISSUE/WAIT/DONE).
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration instead of fixed data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_wl,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [1:0]        m_wl,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int              LAT      = lat_clamp(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_id_t           gnt_q, gnt_d;
    logic              cmd_we_q, cmd_we_d;
    logic [1:0]        cmd_wl_q, cmd_wl_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              capture_s;
    logic              pick_valid_s;
    req_id_t           pick_id_s;
`ifdef MEM_PORT_ARB_RR_EN
    req_id_t           last_gnt_q, last_gnt_d;
`endif

    arb_pick u_pick (
        .if_req_i    (if_req),
        .d_req_i     (d_req),
`ifdef MEM_PORT_ARB_RR_EN
        .last_gnt_i  (last_gnt_q),
`endif
        .gnt_valid_o (pick_valid_s),
        .gnt_id_o    (pick_id_s)
    );

    // Next-state, command latch and read-data capture decision.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        cmd_we_d    = cmd_we_q;
        cmd_wl_d    = cmd_wl_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        capture_s   = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
        last_gnt_d  = last_gnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_ISSUE;
                    gnt_d   = pick_id_s;
`ifdef MEM_PORT_ARB_RR_EN
                    last_gnt_d = pick_id_s;
`endif
                    if (pick_id_s == REQ_D) begin
                        cmd_we_d    = d_we;
                        cmd_wl_d    = d_wl;
                        cmd_addr_d  = d_addr;
                        cmd_wdata_d = d_wdata;
                    end else begin
                        cmd_we_d    = 1'b0;
                        cmd_wl_d    = WL_WORD;
                        cmd_addr_d  = if_addr;
                        cmd_wdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d = CNT_LOAD;
                // Single-cycle memories return data in the issue cycle itself.
                if (LAT == 1) begin
                    capture_s = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    capture_s = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command and read-data registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            gnt_q       <= REQ_D;
            cmd_we_q    <= 1'b0;
            cmd_wl_q    <= 2'd0;
            cmd_addr_q  <= {ADDR_W{1'b0}};
            cmd_wdata_q <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
`ifdef MEM_PORT_ARB_RR_EN
            last_gnt_q  <= REQ_D;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            cmd_we_q    <= cmd_we_d;
            cmd_wl_q    <= cmd_wl_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_gnt_q  <= last_gnt_d;
`endif
            // Stores leave d_rdata untouched.
            if (capture_s && (gnt_q == REQ_IF)) begin
                if_rdata_q <= m_rdata;
            end
            if (capture_s && (gnt_q == REQ_D) && !cmd_we_q) begin
                d_rdata_q <= m_rdata;
            end
        end
    end

    assign m_en      = (state_q == ST_ISSUE);
    assign m_we      = m_en & cmd_we_q;
    assign m_wl      = m_en ? cmd_wl_q    : 2'd0;
    assign m_addr    = m_en ? cmd_addr_q  : {ADDR_W{1'b0}};
    assign m_wdata   = m_en ? cmd_wdata_q : {DATA_W{1'b0}};
    assign if_ack    = (state_q == ST_DONE) && (gnt_q == REQ_IF);
    assign d_ack     = (state_q == ST_DONE) && (gnt_q == REQ_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=4 reset instance).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [1:0]  d_wl;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        if_ack, d_ack, m_en, m_we, stall_if, stall_mem;
    logic [1:0]  m_wl;

    logic        rst4_n, if_req4;
    logic [31:0] if_addr4;
    logic        d_req4, d_we4;
    logic [1:0]  d_wl4;
    logic [31:0] d_addr4, d_wdata4, m_rdata4;
    logic [31:0] if_rdata4, d_rdata4, m_addr4, m_wdata4;
    logic        if_ack4, d_ack4, m_en4, m_we4, stall_if4, stall_mem4;
    logic [1:0]  m_wl4;

    logic [7:0]  a_lat;
    logic [31:0] word100;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        first_is_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_wl(d_wl), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_wl(m_wl), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n),
        .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_ack(if_ack4),
        .d_req(d_req4), .d_we(d_we4), .d_wl(d_wl4), .d_addr(d_addr4), .d_wdata(d_wdata4),
        .d_rdata(d_rdata4), .d_ack(d_ack4),
        .m_en(m_en4), .m_we(m_we4), .m_wl(m_wl4), .m_addr(m_addr4), .m_wdata(m_wdata4),
        .m_rdata(m_rdata4), .stall_if(stall_if4), .stall_mem(stall_mem4)
    );

    // Tiny memory model: latches the address on issue, one writable word at 0x100.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat   <= 8'd0;
            word100 <= 32'h1122_3344;
        end else if (m_en) begin
            a_lat <= m_addr[9:2];
            if (m_we && (m_addr[9:2] == 8'h40)) begin
                word100 <= m_wdata;
            end
        end
    end

    assign m_rdata = (a_lat == 8'h10) ? 32'h0050_0093 :
                     (a_lat == 8'h12) ? 32'h0000_0013 :
                     (a_lat == 8'h40) ? word100 : 32'hBAD0_BAD0;
    assign m_rdata4 = 32'hCAFE_0001;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
`ifdef MEM_PORT_ARB_RR_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        rst_n = 1'b0; rst4_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h48;
        d_req = 1'b1; d_we = 1'b0; d_wl = 2'd2; d_addr = 32'h100; d_wdata = 32'h0;
        if_req4 = 1'b0; if_addr4 = 32'h0; d_req4 = 1'b0; d_we4 = 1'b0; d_wl4 = 2'd0;
        d_addr4 = 32'h0; d_wdata4 = 32'h0;

        // Reset with both requests held.
        repeat (2) tick();
        check_eq("rst_m_en", {31'd0, m_en}, 32'd0);
        check_eq("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_d_rdata", d_rdata, 32'd0);

        // Contention straight out of reset.
        rst_n = 1'b1; rst4_n = 1'b1;
        #1 check_eq("c0_m_en", {31'd0, m_en}, 32'd0);
        check_eq("c0_stalls", {30'd0, stall_if, stall_mem}, 32'd3);
        tick();
        check_eq("c1_m_en", {31'd0, m_en}, 32'd1);
        check_eq("c1_m_addr", m_addr, first_is_d ? 32'h100 : 32'h48);
        check_eq("c1_m_wl", {30'd0, m_wl}, 32'd2);
        check_eq("c1_m_we", {31'd0, m_we}, 32'd0);
        tick();
        check_eq("c2_m_en", {31'd0, m_en}, 32'd0);
        tick();
        check_eq("c3_d_ack", {31'd0, d_ack}, {31'd0, first_is_d});
        check_eq("c3_if_ack", {31'd0, if_ack}, {31'd0, ~first_is_d});
        check_eq("c3_stalls", {30'd0, stall_if, stall_mem}, first_is_d ? 32'd2 : 32'd1);
        if (first_is_d) begin
            check_eq("c3_d_rdata", d_rdata, 32'h1122_3344);
            d_req = 1'b0;
        end else begin
            check_eq("c3_if_rdata", if_rdata, 32'h0000_0013);
            if_req = 1'b0;
        end
        tick();
        check_eq("c4_m_en", {31'd0, m_en}, 32'd0);
        tick();
        check_eq("c5_m_en", {31'd0, m_en}, 32'd1);
        check_eq("c5_m_addr", m_addr, first_is_d ? 32'h48 : 32'h100);
        tick();
        tick();
        check_eq("c7_if_ack", {31'd0, if_ack}, {31'd0, first_is_d});
        check_eq("c7_d_ack", {31'd0, d_ack}, {31'd0, ~first_is_d});
        check_eq("c7_if_rdata", if_rdata, 32'h0000_0013);
        check_eq("c7_d_rdata", d_rdata, 32'h1122_3344);
        if_req = 1'b0; d_req = 1'b0;

        // Single fetch at 0x40.
        tick();
        if_req = 1'b1; if_addr = 32'h40;
        #1 check_eq("f0_stall_if", {31'd0, stall_if}, 32'd1);
        tick();
        check_eq("f1_m_en", {31'd0, m_en}, 32'd1);
        check_eq("f1_m_addr", m_addr, 32'h40);
        check_eq("f1_m_we_wl", {29'd0, m_we, m_wl}, 32'd2);
        tick();
        check_eq("f2_stall_if", {31'd0, stall_if}, 32'd1);
        check_eq("f2_m_addr_idle", m_addr, 32'd0);
        tick();
        check_eq("f3_if_ack", {31'd0, if_ack}, 32'd1);
        check_eq("f3_if_rdata", if_rdata, 32'h0050_0093);
        check_eq("f3_stall_if", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0;

        // Store 0xDEADBEEF at 0x100, then load it back with half width.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_wl = 2'd2; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("s1_m_we", {31'd0, m_we}, 32'd1);
        check_eq("s1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check_eq("s1_m_addr", m_addr, 32'h100);
        tick();
        check_eq("s2_m_we", {31'd0, m_we}, 32'd0);
        check_eq("s2_m_wdata", m_wdata, 32'd0);
        tick();
        check_eq("s3_d_ack", {31'd0, d_ack}, 32'd1);
        check_eq("s3_d_rdata_kept", d_rdata, 32'h1122_3344);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_wl = 2'd1;
        tick();
        check_eq("l1_m_wl", {30'd0, m_wl}, 32'd1);
        check_eq("l1_m_we", {31'd0, m_we}, 32'd0);
        tick();
        tick();
        check_eq("l3_d_ack", {31'd0, d_ack}, 32'd1);
        check_eq("l3_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;

        // MEM_LAT=4 instance: reset during WAIT, then reissue.
        tick();
        if_req4 = 1'b1; if_addr4 = 32'h80;
        tick();
        check_eq("r1_m_en", {31'd0, m_en4}, 32'd1);
        check_eq("r1_m_addr", m_addr4, 32'h80);
        tick();
        tick();
        rst4_n = 1'b0;
        #1 check_eq("r_rst_m_en", {31'd0, m_en4}, 32'd0);
        check_eq("r_rst_if_ack", {31'd0, if_ack4}, 32'd0);
        tick();
        check_eq("r_rst_hold_ack", {31'd0, if_ack4}, 32'd0);
        check_eq("r_rst_if_rdata", if_rdata4, 32'd0);
        rst4_n = 1'b1;
        #1 check_eq("r0_m_en", {31'd0, m_en4}, 32'd0);
        tick();
        check_eq("rr1_m_en", {31'd0, m_en4}, 32'd1);
        check_eq("rr1_m_addr", m_addr4, 32'h80);
        tick();
        check_eq("rr2_m_en", {31'd0, m_en4}, 32'd0);
        tick();
        tick();
        check_eq("rr4_if_ack", {31'd0, if_ack4}, 32'd0);
        tick();
        check_eq("rr5_if_ack", {31'd0, if_ack4}, 32'd1);
        check_eq("rr5_if_rdata", if_rdata4, 32'hCAFE_0001);
        if_req4 = 1'b0;
        tick();
        check_eq("rr6_if_ack", {31'd0, if_ack4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
